// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: assembles framed host bytes into
// 25-bit words, writes them from address 0 and holds the CPU until a good checksum.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 25
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              ImemWrite,
  output logic [ADDR_W-1:0] ImemAddress,
  output logic [INST_W-1:0] ImemDatain,
  output logic              CpuHold,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [1:0]        ErrCode
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    PAYLOAD,
    WRITE,
    CHECK,
    ERROR
  } state_t;

  state_t      state, nextState;
  logic [7:0]  countN;
  logic [7:0]  wordCnt;
  logic [7:0]  checksum;
  logic [1:0]  byteIdx;
  logic        accept;
  logic        lastWord;
  logic        badPad;

  assign accept   = ByteValid && ByteReady;
  assign lastWord = (wordCnt == countN);
  assign badPad   = (byteIdx == 2'd0) && (ByteIn[7:1] != '0);

  always_comb begin
    nextState = state;
    ByteReady = 1'b0;
    ImemWrite = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (Start) nextState = COUNT;
      end
      COUNT: begin
        ByteReady = 1'b1;
        if (ByteValid) nextState = PAYLOAD;
      end
      PAYLOAD: begin
        ByteReady = 1'b1;
        if (ByteValid) begin
          if (badPad)                 nextState = ERROR;
          else if (byteIdx == 2'd3)   nextState = WRITE;
        end
      end
      WRITE: begin
        ImemWrite = 1'b1;
        nextState = lastWord ? CHECK : PAYLOAD;
      end
      CHECK: begin
        ByteReady = 1'b1;
        if (ByteValid) nextState = (ByteIn == checksum) ? IDLE : ERROR;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      countN      <= '0;
      wordCnt     <= '0;
      checksum    <= '0;
      byteIdx     <= '0;
      ImemAddress <= '0;
      ImemDatain  <= '0;
      CpuHold     <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      ErrCode     <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE, ERROR: begin
          if (Start) begin
            CpuHold     <= 1'b1;
            Busy        <= 1'b1;
            Done        <= 1'b0;
            Error       <= 1'b0;
            ErrCode     <= '0;
            ImemAddress <= '0;
            wordCnt     <= '0;
            checksum    <= '0;
            byteIdx     <= '0;
          end
        end
        COUNT: begin
          if (accept) begin
            countN   <= ByteIn;
            checksum <= checksum ^ ByteIn;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            checksum   <= checksum ^ ByteIn;
            // MSB-first shift; byte0 bits [7:1] fall off the top after four bytes
            ImemDatain <= {ImemDatain[INST_W-9:0], ByteIn};
            byteIdx    <= byteIdx + 2'd1;
            if (badPad) begin
              Error   <= 1'b1;
              Busy    <= 1'b0;
              ErrCode <= 2'b01;
            end
          end
        end
        WRITE: begin
          if (!lastWord) begin
            ImemAddress <= ImemAddress + ADDR_W'(1);
            wordCnt     <= wordCnt + 8'd1;
            byteIdx     <= '0;
          end
        end
        CHECK: begin
          if (accept) begin
            Busy <= 1'b0;
            if (ByteIn == checksum) begin
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              Error   <= 1'b1;
              ErrCode <= 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: framed loads, error paths, handshake
// stalls, asynchronous abort and a full 256-word load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        ImemWrite;
  logic [7:0]  ImemAddress;
  logic [24:0] ImemDatain;
  logic        CpuHold;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [1:0]  ErrCode;

  int nAssert = 0;
  int nFail   = 0;
  logic        holdValid = 1'b0;
  int          gapMax    = 0;
  logic [7:0]  wrAddr[$];
  logic [24:0] wrData[$];

  logic [7:0] s1[10] = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'hF9};

  imem_loader #(.ADDR_W(8), .INST_W(25)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .ImemWrite(ImemWrite), .ImemAddress(ImemAddress),
    .ImemDatain(ImemDatain), .CpuHold(CpuHold), .Busy(Busy), .Done(Done),
    .Error(Error), .ErrCode(ErrCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record every write strobe; the loader must never offer ready while writing.
  always @(negedge clk) begin
    if (Reset === 1'b1 && ImemWrite === 1'b1) begin
      wrAddr.push_back(ImemAddress);
      wrData.push_back(ImemDatain);
      chk("readyInWrite", {31'b0, ByteReady}, 32'h0);
    end
  end

  task automatic clearWrites();
    wrAddr.delete();
    wrData.delete();
  endtask

  // Called about 1 time unit after a rising edge; returns 1 unit after the transfer edge.
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    @(negedge clk);
    while (ByteReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("byteTimeout", 32'(n), 32'h0);
      ByteValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!holdValid) ByteValid = 1'b0;
    if (gapMax > 0) begin
      ByteValid = 1'b0;
      repeat ($urandom_range(0, gapMax)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic doStart();
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic checkScenario1Writes(input string tag);
    chk({tag, "_nWrites"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      chk({tag, "_addr0"}, {24'b0, wrAddr[0]}, 32'h0);
      chk({tag, "_data0"}, {7'b0, wrData[0]}, 32'h0123456);
      chk({tag, "_addr1"}, {24'b0, wrAddr[1]}, 32'h1);
      chk({tag, "_data1"}, {7'b0, wrData[1]}, 32'h1ABCDEF);
    end
  endtask

  initial begin
    int bad;
    Reset = 1'b1; Start = 1'b0; ByteIn = '0; ByteValid = 1'b0;
    #3 Reset = 1'b0;
    #1;
    chk("rst_outputs", {ByteReady, ImemWrite, ImemAddress, CpuHold, Busy, Done, Error, ErrCode}, 32'h0);
    chk("rst_datain", {7'b0, ImemDatain}, 32'h0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: good two-word load, Start pulsed mid-load must be ignored
    clearWrites();
    doStart();
    chk("s1_startFlags", {28'b0, CpuHold, Busy, Done, Error}, 32'b1100);
    chk("s1_countReady", {31'b0, ByteReady}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) Start = 1'b1;
      sendByte(s1[i]);
      Start = 1'b0;
    end
    chk("s1_writeLatency", {31'b0, ImemWrite}, 32'h1);
    chk("s1_writeAddr", {24'b0, ImemAddress}, 32'h0);
    chk("s1_writeData", {7'b0, ImemDatain}, 32'h0123456);
    for (int i = 5; i < 10; i++) sendByte(s1[i]);
    checkScenario1Writes("s1");
    chk("s1_status", {27'b0, Done, CpuHold, Error, Busy, ByteReady}, 32'b10000);

    // Scenario 2: same stream, bad checksum
    clearWrites();
    doStart();
    for (int i = 0; i < 9; i++) sendByte(s1[i]);
    sendByte(8'h00);
    chk("s2_nWrites", 32'(wrAddr.size()), 32'd2);
    chk("s2_status", {28'b0, Done, CpuHold, Error, Busy}, 32'b0110);
    chk("s2_errCode", {30'b0, ErrCode}, 32'h2);

    // Scenario 3: nonzero pad bits in byte0, restarted from ERROR
    clearWrites();
    doStart();
    chk("s3_restartClears", {29'b0, Error, ErrCode}, 32'h0);
    sendByte(8'h00);
    sendByte(8'h02);
    chk("s3_error", {31'b0, Error}, 32'h1);
    chk("s3_errCode", {30'b0, ErrCode}, 32'h1);
    chk("s3_ready", {31'b0, ByteReady}, 32'h0);
    chk("s3_hold", {30'b0, CpuHold, Busy}, 32'b10);
    repeat (3) @(posedge clk);
    #1;
    chk("s3_nWrites", 32'(wrAddr.size()), 32'd0);

    // Scenario 4a: ByteValid held high throughout
    clearWrites();
    holdValid = 1'b1;
    doStart();
    for (int i = 0; i < 10; i++) sendByte(s1[i]);
    ByteValid = 1'b0;
    holdValid = 1'b0;
    checkScenario1Writes("s4a");
    chk("s4a_done", {30'b0, Done, Error}, 32'b10);

    // Scenario 4b: random gaps between bytes
    clearWrites();
    gapMax = 3;
    doStart();
    for (int i = 0; i < 10; i++) sendByte(s1[i]);
    gapMax = 0;
    checkScenario1Writes("s4b");
    chk("s4b_done", {30'b0, Done, Error}, 32'b10);

    // Scenario 5: asynchronous abort after three payload bytes, then clean reload
    clearWrites();
    doStart();
    for (int i = 0; i < 4; i++) sendByte(s1[i]);
    #2 Reset = 1'b0;
    #1;
    chk("s5_outputs", {ByteReady, ImemWrite, ImemAddress, CpuHold, Busy, Done, Error, ErrCode}, 32'h0);
    chk("s5_datain", {7'b0, ImemDatain}, 32'h0);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    clearWrites();
    doStart();
    for (int i = 0; i < 10; i++) sendByte(s1[i]);
    checkScenario1Writes("s5");
    chk("s5_done", {29'b0, Done, CpuHold, Error}, 32'b100);

    // Scenario 6: N=FF, 256 words with word k = k; checksum is FF since XOR of 0..255 is 0
    clearWrites();
    doStart();
    sendByte(8'hFF);
    for (int k = 0; k < 256; k++) begin
      sendByte(8'h00);
      sendByte(8'h00);
      sendByte(8'h00);
      sendByte(8'(k));
    end
    sendByte(8'hFF);
    chk("s6_nWrites", 32'(wrAddr.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wrAddr.size(); i++)
      if (wrAddr[i] !== 8'(i) || wrData[i] !== 25'(i)) bad++;
    chk("s6_badWords", 32'(bad), 32'h0);
    if (wrAddr.size() > 0) begin
      chk("s6_lastAddr", {24'b0, wrAddr[wrAddr.size()-1]}, 32'hFF);
      chk("s6_lastData", {7'b0, wrData[wrData.size()-1]}, 32'hFF);
    end
    chk("s6_status", {28'b0, Done, CpuHold, Error, Busy}, 32'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
